// File: rtl/line_buffer_3row_pkg.sv
// Shared defaults for the 3-row line buffer and the 3x3 stages it feeds.
package line_buffer_3row_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int PIC_WIDTH_DEF  = 250;
  localparam int PIC_HEIGHT_DEF = 250;

  // Counter width for n positions; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = cnt_w(PIC_WIDTH_DEF);
  localparam int ROW_W = cnt_w(PIC_HEIGHT_DEF);

endpackage

// File: rtl/line_buffer_3row_line_ram.sv
// One line of pixel storage: synchronous registered read, independent write,
// read-before-write on an address collision. Only the read register is reset.
module line_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 250,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port; contents are never cleared.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read; holds its value when not reading, returns old data on a same-address write.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/line_buffer_3row.sv
// Raster stream to three vertically aligned row taps (rows r-2, r-1, r),
// one-cycle latency, output gated until two rows of the frame are stored.
module line_buffer_3row
  import line_buffer_3row_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PIC_WIDTH  = PIC_WIDTH_DEF,
  parameter int PIC_HEIGHT = PIC_HEIGHT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] din,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3
);

  localparam int CW = (PIC_WIDTH  == PIC_WIDTH_DEF)  ? CNT_W : cnt_w(PIC_WIDTH);
  localparam int RW = (PIC_HEIGHT == PIC_HEIGHT_DEF) ? ROW_W : cnt_w(PIC_HEIGHT);

  localparam logic [CW-1:0] COL_LAST  = CW'(PIC_WIDTH - 1);
  localparam logic [CW-1:0] COL_ONE   = CW'(1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(PIC_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE   = RW'(1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(2);

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic             r_valid;
  logic [WIDTH-1:0] r_dout3;
  logic             r_pend;
  logic [CW-1:0]    r_pend_col;

  logic             w_accept;
  logic [CW-1:0]    w_col;
  logic [RW-1:0]    w_row;
  logic [WIDTH-1:0] w_rdata_a;
  logic [WIDTH-1:0] w_rdata_b;

  // A qualified sof makes this pixel (0,0) regardless of the counters.
  assign w_accept = valid_in && !rst;
  assign w_col    = sof ? '0 : r_col;
  assign w_row    = sof ? '0 : r_row;

  // Newest stored row: read old value, overwrite with the incoming pixel.
  line_ram #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH), .AW(CW)) u_ram_b (
    .clk     (clk),
    .rst     (rst),
    .i_re    (w_accept),
    .i_raddr (w_col),
    .o_rdata (w_rdata_b),
    .i_we    (w_accept),
    .i_waddr (w_col),
    .i_wdata (din)
  );

  // Oldest stored row. The value it must take (the old ram_b word) only
  // exists at the ram_b read register one cycle later, so its write is
  // deferred by one cycle. A read can only meet that pending write at the
  // same column when sof restarts at column 0 right after a column-0 pixel;
  // that read lands in row 0, whose output is gated off, so no bypass is kept.
  line_ram #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH), .AW(CW)) u_ram_a (
    .clk     (clk),
    .rst     (rst),
    .i_re    (w_accept),
    .i_raddr (w_col),
    .o_rdata (w_rdata_a),
    .i_we    (r_pend),
    .i_waddr (r_pend_col),
    .i_wdata (w_rdata_b)
  );

  // Remember which column owes ram_a its shifted-down word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= 1'b0;
      r_pend_col <= '0;
    end else begin
      r_pend     <= valid_in;
      r_pend_col <= w_col;
    end
  end

  // Raster position counters; row wraps at the frame height so frames may run back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (valid_in) begin
      if (w_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row == ROW_LAST) ? '0 : w_row + ROW_ONE;
      end else begin
        r_col <= w_col + COL_ONE;
        r_row <= w_row;
      end
    end
  end

  // Current-row tap and output qualifier, both one cycle behind the input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_dout3 <= '0;
    end else begin
      r_valid <= valid_in && (w_row >= ROW_FIRST);
      if (valid_in) r_dout3 <= din;
    end
  end

  assign valid_out = r_valid;
  assign dout1     = w_rdata_a;
  assign dout2     = w_rdata_b;
  assign dout3     = r_dout3;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row: image-array reference model plus directed frames and a random soak.
module tb_line_buffer_3row;

  localparam int W  = 8;
  localparam int PW = 4;
  localparam int PH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sof = 1'b0;
  logic         valid_in = 1'b0;
  logic [W-1:0] din = '0;
  logic         valid_out;
  logic [W-1:0] dout1, dout2, dout3;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  bit armed    = 1'b0;

  always #5 clk = ~clk;

  line_buffer_3row #(.WIDTH(W), .PIC_WIDTH(PW), .PIC_HEIGHT(PH)) dut (
    .clk       (clk),
    .rst       (rst),
    .sof       (sof),
    .valid_in  (valid_in),
    .din       (din),
    .valid_out (valid_out),
    .dout1     (dout1),
    .dout2     (dout2),
    .dout3     (dout3)
  );

  // Reference: the current frame as a 2-D image plus a raster position.
  logic [W-1:0] img [PH][PW];
  int           m_r = 0, m_c = 0;
  int           cur_r, cur_c;
  logic         e_valid = 1'b0;
  logic [W-1:0] e_d1 = '0, e_d2 = '0, e_d3 = '0;
  bit           e_kn12 = 1'b1, e_kn3 = 1'b1;

  always_comb begin
    cur_r = sof ? 0 : m_r;
    cur_c = sof ? 0 : m_c;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_r <= 0; m_c <= 0;
      e_valid <= 1'b0;
      e_d1 <= '0; e_d2 <= '0; e_d3 <= '0;
      e_kn12 <= 1'b1; e_kn3 <= 1'b1;
    end else if (valid_in) begin
      img[cur_r][cur_c] <= din;
      e_valid <= (cur_r >= 2);
      e_d3    <= din;
      e_kn3   <= 1'b1;
      if (cur_r >= 2) begin
        e_d1   <= img[cur_r-2][cur_c];
        e_d2   <= img[cur_r-1][cur_c];
        e_kn12 <= 1'b1;
      end else begin
        e_kn12 <= 1'b0;
      end
      if (cur_c == PW-1) begin
        m_c <= 0;
        m_r <= (cur_r == PH-1) ? 0 : cur_r + 1;
      end else begin
        m_c <= cur_c + 1;
        m_r <= cur_r;
      end
    end else begin
      e_valid <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: outputs versus the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("valid_out", {7'b0, valid_out}, {7'b0, e_valid});
      if (e_kn3)  chk("dout3", dout3, e_d3);
      if (e_kn12) begin
        chk("dout1", dout1, e_d1);
        chk("dout2", dout2, e_d2);
      end
      if (valid_out === 1'b1)
        $display("OUT t=%0t dout1=0x%02h dout2=0x%02h dout3=0x%02h", $time, dout1, dout2, dout3);
    end
  end

  task automatic step(input bit r, input bit s, input bit v, input logic [W-1:0] d);
    rst = r; sof = s; valid_in = v; din = d;
    @(negedge clk);
    if (valid_out === 1'b1) pulses++;
  endtask

  // Feed one frame of row*16+col pixels. cut_at stops before that pixel index,
  // rst_at replaces that pixel with a reset cycle, hold_at inserts 5 idle sof cycles before it.
  task automatic frame(input bit with_sof, input bit gap, input int cut_at,
                       input int rst_at, input int hold_at);
    pulses = 0;
    for (int r = 0; r < PH; r++) begin
      for (int c = 0; c < PW; c++) begin
        int idx;
        idx = r*PW + c;
        if (idx == cut_at) return;
        if (idx == hold_at)
          for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, W'($urandom));
        if (idx == rst_at) begin
          step(1'b1, 1'b0, 1'b1, W'(r*16 + c));
          chk("rst valid_out", {7'b0, valid_out}, 8'h00);
          chk("rst dout1", dout1, 8'h00);
          chk("rst dout2", dout2, 8'h00);
          chk("rst dout3", dout3, 8'h00);
          return;
        end
        step(1'b0, with_sof && idx == 0, 1'b1, W'(r*16 + c));
        if (r == 1 && c == PW-1) chk_int("no output rows 0-1", pulses, 0);
        if (r == 2 && c == 0) begin
          chk("first valid", {7'b0, valid_out}, 8'h01);
          chk("first dout1", dout1, 8'h00);
          chk("first dout2", dout2, 8'h10);
          chk("first dout3", dout3, 8'h20);
        end
        if (gap) step(1'b0, 1'b0, 1'b0, W'($urandom));
      end
    end
    chk_int("pulses per frame", pulses, 8);
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    armed = 1'b1;
    chk("reset valid_out", {7'b0, valid_out}, 8'h00);
    chk("reset dout1", dout1, 8'h00);
    chk("reset dout2", dout2, 8'h00);
    chk("reset dout3", dout3, 8'h00);

    frame(1'b1, 1'b0, -1, -1, -1);   // continuous
    frame(1'b1, 1'b1, -1, -1, -1);   // valid toggled every cycle
    frame(1'b1, 1'b0, -1, -1, -1);   // back to back, second without sof
    frame(1'b0, 1'b0, -1, -1, -1);
    frame(1'b1, 1'b0, 10, -1, -1);   // cut at (2,2), then resync with sof
    frame(1'b1, 1'b0, -1, -1, -1);
    frame(1'b1, 1'b0, -1, 13, -1);   // reset at (3,1)
    frame(1'b0, 1'b0, -1, -1, -1);
    frame(1'b1, 1'b0, -1, -1, 14);   // sof held idle before (3,2)

    for (int i = 0; i < 4000; i++) begin
      bit v, s, r;
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 599) == 0);
      step(r, s, v, W'($urandom));
    end
    step(1'b0, 1'b0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
